// File: rtl/elevator_pkg.sv
// Shared floor/state encodings and floor-set helpers for the elevator motion scheduler.
package elevator_pkg;

    localparam logic [1:0] FLOOR_G    = 2'b00;
    localparam logic [1:0] FLOOR_1    = 2'b01;
    localparam logic [1:0] FLOOR_2    = 2'b10;
    localparam int         NUM_FLOORS = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10,
        DOOR_OPEN = 2'b11
    } state_t;

    function automatic logic floor_hit(input logic [NUM_FLOORS-1:0] set,
                                       input logic [1:0]            f);
        logic hit;
        hit = 1'b0;
        case (f)
            FLOOR_G: hit = set[0];
            FLOOR_1: hit = set[1];
            FLOOR_2: hit = set[2];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [1:0] f);
        logic [NUM_FLOORS-1:0] mask;
        mask = '0;
        case (f)
            FLOOR_G: mask = 3'b001;
            FLOOR_1: mask = 3'b010;
            FLOOR_2: mask = 3'b100;
            default: mask = '0;
        endcase
        return mask;
    endfunction

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] set,
                                       input logic [1:0]            f);
        logic r;
        r = 1'b0;
        case (f)
            FLOOR_G: r = set[1] | set[2];
            FLOOR_1: r = set[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] set,
                                       input logic [1:0]            f);
        logic r;
        r = 1'b0;
        case (f)
            FLOOR_1: r = set[0];
            FLOOR_2: r = set[0] | set[1];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Closest requested floor strictly beyond f in the given direction; f itself if none.
    function automatic logic [1:0] nearest_floor(input logic [NUM_FLOORS-1:0] set,
                                                 input logic [1:0]            f,
                                                 input logic                  up);
        logic [1:0] r;
        r = f;
        if (up) begin
            case (f)
                FLOOR_G: begin
                    if (set[1])      r = FLOOR_1;
                    else if (set[2]) r = FLOOR_2;
                end
                FLOOR_1: begin
                    if (set[2])      r = FLOOR_2;
                end
                default: r = f;
            endcase
        end else begin
            case (f)
                FLOOR_2: begin
                    if (set[1])      r = FLOOR_1;
                    else if (set[0]) r = FLOOR_G;
                end
                FLOOR_1: begin
                    if (set[0])      r = FLOOR_G;
                end
                default: r = f;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Loadable down-counter with zero flag, used for travel and door dwell timing.
module elev_tick_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    // Load wins over decrement; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_motion_scheduler.sv
// SCAN request scheduler and motion sequencer for a 3-floor elevator.
module elevator_motion_scheduler
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 3,
    parameter int TMR_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [1:0]            c_f,
    output logic [1:0]            n_f,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  moving,
    output logic                  dir_up
);

    localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_TICKS - 1);
    localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_TICKS - 1);

    state_t                state;
    state_t                state_nx;
    logic [1:0]            cf_nx;
    logic [1:0]            nf_nx;
    logic                  dir_nx;
    logic [NUM_FLOORS-1:0] eff;
    logic [NUM_FLOORS-1:0] pending_nx;
    logic                  above;
    logic                  below;
    logic                  travel_load;
    logic                  travel_dec;
    logic                  travel_zero;
    logic                  door_load;
    logic                  door_dec;
    logic                  door_zero;

    assign eff   = pending | req;
    assign above = any_above(eff, c_f);
    assign below = any_below(eff, c_f);

    always_comb begin
        state_nx    = state;
        cf_nx       = c_f;
        dir_nx      = dir_up;
        travel_load = 1'b0;
        door_load   = 1'b0;
        case (state)
            IDLE: begin
                if (floor_hit(eff, c_f)) begin
                    state_nx  = DOOR_OPEN;
                    door_load = 1'b1;
                end else if (dir_up && above) begin
                    state_nx    = MOVE_UP;
                    travel_load = 1'b1;
                end else if (!dir_up && below) begin
                    state_nx    = MOVE_DOWN;
                    travel_load = 1'b1;
                end else if (above) begin
                    state_nx    = MOVE_UP;
                    dir_nx      = 1'b1;
                    travel_load = 1'b1;
                end else if (below) begin
                    state_nx    = MOVE_DOWN;
                    dir_nx      = 1'b0;
                    travel_load = 1'b1;
                end
            end
            MOVE_UP: begin
                if (travel_zero) begin
                    if (c_f != FLOOR_2) begin
                        cf_nx = c_f + 2'd1;
                        if (floor_hit(eff, cf_nx)) begin
                            state_nx  = DOOR_OPEN;
                            door_load = 1'b1;
                        end else if (any_above(eff, cf_nx)) begin
                            travel_load = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (travel_zero) begin
                    if (c_f != FLOOR_G) begin
                        cf_nx = c_f - 2'd1;
                        if (floor_hit(eff, cf_nx)) begin
                            state_nx  = DOOR_OPEN;
                            door_load = 1'b1;
                        end else if (any_below(eff, cf_nx)) begin
                            travel_load = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // A held call button at this floor keeps the door open.
                if (floor_hit(req, c_f))
                    door_load = 1'b1;
                else if (door_zero)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pending_nx = eff;
        if (state_nx == DOOR_OPEN)
            pending_nx = eff & ~floor_mask(cf_nx);
    end

    always_comb begin
        nf_nx = cf_nx;
        case (state_nx)
            MOVE_UP:   nf_nx = nearest_floor(eff, cf_nx, 1'b1);
            MOVE_DOWN: nf_nx = nearest_floor(eff, cf_nx, 1'b0);
            default:   nf_nx = cf_nx;
        endcase
    end

    assign travel_dec = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_dec   = (state == DOOR_OPEN);

    elev_tick_timer #(.TMR_W(TMR_W)) u_travel_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (travel_load),
        .load_val (TRAVEL_LOAD),
        .dec      (travel_dec),
        .zero     (travel_zero)
    );

    elev_tick_timer #(.TMR_W(TMR_W)) u_door_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (door_load),
        .load_val (DOOR_LOAD),
        .dec      (door_dec),
        .zero     (door_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            c_f       <= FLOOR_G;
            n_f       <= FLOOR_G;
            pending   <= '0;
            door_open <= 1'b0;
            moving    <= 1'b0;
            dir_up    <= 1'b1;
        end else begin
            state     <= state_nx;
            c_f       <= cf_nx;
            n_f       <= nf_nx;
            pending   <= pending_nx;
            door_open <= (state_nx == DOOR_OPEN);
            moving    <= (state_nx == MOVE_UP) || (state_nx == MOVE_DOWN);
            dir_up    <= dir_nx;
        end
    end

endmodule

// File: tb/tb_elevator_motion_scheduler.sv
// Directed self-checking bench for elevator_motion_scheduler (TRAVEL_TICKS=4, DOOR_TICKS=3).
module tb_elevator_motion_scheduler;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [1:0] c_f;
    logic [1:0] n_f;
    logic [2:0] pending;
    logic       door_open;
    logic       moving;
    logic       dir_up;

    int total = 0;
    int bad   = 0;

    elevator_motion_scheduler #(
        .TRAVEL_TICKS (4),
        .DOOR_TICKS   (3),
        .TMR_W        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .c_f       (c_f),
        .n_f       (n_f),
        .pending   (pending),
        .door_open (door_open),
        .moving    (moving),
        .dir_up    (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive req, then advance n edges; outputs are sampled 1 time unit after the last edge.
    task automatic applyStimulus(input logic [2:0] r, input int n);
        req = r;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 3'b000;

        // Reset with a request present: request must be discarded
        applyStimulus(3'b100, 2);
        checkOutput("rst_cf", c_f, 0);
        checkOutput("rst_nf", n_f, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_door", door_open, 0);
        checkOutput("rst_moving", moving, 0);
        checkOutput("rst_dir", dir_up, 1);
        reset = 1'b0;
        applyStimulus(3'b000, 1);
        checkOutput("idle_pending", pending, 0);
        checkOutput("idle_nf", n_f, 0);
        checkOutput("idle_moving", moving, 0);

        // Full trip ground -> second floor
        applyStimulus(3'b100, 1);
        checkOutput("trip_pending", pending, 3'b100);
        checkOutput("trip_nf", n_f, 2);
        checkOutput("trip_moving", moving, 1);
        checkOutput("trip_cf0", c_f, 0);
        applyStimulus(3'b000, 3);
        checkOutput("trip_cf_still0", c_f, 0);
        applyStimulus(3'b000, 1);
        checkOutput("trip_cf1", c_f, 1);
        checkOutput("trip_moving1", moving, 1);
        applyStimulus(3'b000, 4);
        checkOutput("trip_cf2", c_f, 2);
        checkOutput("trip_door", door_open, 1);
        checkOutput("trip_moving_off", moving, 0);
        checkOutput("trip_pending_clr", pending, 0);
        checkOutput("trip_nf_door", n_f, 2);
        applyStimulus(3'b000, 2);
        checkOutput("trip_door_3rd", door_open, 1);
        applyStimulus(3'b000, 1);
        checkOutput("trip_door_closed", door_open, 0);
        checkOutput("trip_idle_moving", moving, 0);

        // Reset asserted mid-motion while travelling down
        applyStimulus(3'b001, 1);
        checkOutput("down_moving", moving, 1);
        checkOutput("down_dir", dir_up, 0);
        checkOutput("down_nf", n_f, 0);
        applyStimulus(3'b000, 2);
        reset = 1'b1;
        applyStimulus(3'b000, 1);
        checkOutput("mrst_cf", c_f, 0);
        checkOutput("mrst_nf", n_f, 0);
        checkOutput("mrst_pending", pending, 0);
        checkOutput("mrst_door", door_open, 0);
        checkOutput("mrst_moving", moving, 0);
        checkOutput("mrst_dir", dir_up, 1);
        applyStimulus(3'b000, 1);
        checkOutput("mrst_moving2", moving, 0);
        reset = 1'b0;

        // Intermediate stop at first floor on the way up
        applyStimulus(3'b100, 1);
        checkOutput("mid_nf2", n_f, 2);
        applyStimulus(3'b010, 1);
        checkOutput("mid_pending", pending, 3'b110);
        checkOutput("mid_nf1", n_f, 1);
        applyStimulus(3'b000, 3);
        checkOutput("mid_cf1", c_f, 1);
        checkOutput("mid_door", door_open, 1);
        checkOutput("mid_pending_left", pending, 3'b100);
        checkOutput("mid_nf_door", n_f, 1);
        applyStimulus(3'b000, 2);
        checkOutput("mid_door_3rd", door_open, 1);
        applyStimulus(3'b000, 1);
        checkOutput("mid_door_closed", door_open, 0);
        checkOutput("mid_pending_keep", pending, 3'b100);
        applyStimulus(3'b000, 1);
        checkOutput("mid_resume", moving, 1);
        checkOutput("mid_resume_nf", n_f, 2);
        applyStimulus(3'b000, 4);
        checkOutput("mid_cf2", c_f, 2);
        checkOutput("mid_door2", door_open, 1);
        checkOutput("mid_pending_empty", pending, 0);

        applyStimulus(3'b000, 3);
        reset = 1'b1;
        applyStimulus(3'b000, 1);
        reset = 1'b0;

        // SCAN: a ground call added while climbing is served after the top floor
        applyStimulus(3'b100, 1);
        applyStimulus(3'b000, 4);
        checkOutput("scan_cf1", c_f, 1);
        checkOutput("scan_moving", moving, 1);
        checkOutput("scan_nf2", n_f, 2);
        applyStimulus(3'b001, 1);
        checkOutput("scan_pending", pending, 3'b101);
        checkOutput("scan_nf_keep", n_f, 2);
        applyStimulus(3'b000, 3);
        checkOutput("scan_cf2", c_f, 2);
        checkOutput("scan_door2", door_open, 1);
        checkOutput("scan_pending1", pending, 3'b001);
        checkOutput("scan_dir_up", dir_up, 1);
        applyStimulus(3'b000, 3);
        checkOutput("scan_door_closed", door_open, 0);
        applyStimulus(3'b000, 1);
        checkOutput("scan_down_moving", moving, 1);
        checkOutput("scan_down_dir", dir_up, 0);
        checkOutput("scan_down_nf", n_f, 0);
        applyStimulus(3'b000, 4);
        checkOutput("scan_pass_cf1", c_f, 1);
        checkOutput("scan_pass_moving", moving, 1);
        applyStimulus(3'b000, 4);
        checkOutput("scan_cf0", c_f, 0);
        checkOutput("scan_door0", door_open, 1);
        checkOutput("scan_pending_empty", pending, 0);
        applyStimulus(3'b000, 3);
        checkOutput("scan_final_door", door_open, 0);

        // Door hold at first floor
        applyStimulus(3'b010, 1);
        checkOutput("hold_moving", moving, 1);
        checkOutput("hold_dir", dir_up, 1);
        checkOutput("hold_nf", n_f, 1);
        applyStimulus(3'b000, 4);
        checkOutput("hold_cf1", c_f, 1);
        checkOutput("hold_door", door_open, 1);
        applyStimulus(3'b010, 5);
        checkOutput("hold_door_held", door_open, 1);
        checkOutput("hold_pending", pending, 0);
        applyStimulus(3'b000, 2);
        checkOutput("hold_door_after", door_open, 1);
        applyStimulus(3'b000, 1);
        checkOutput("hold_door_closed", door_open, 0);
        checkOutput("hold_idle_pending", pending, 0);
        checkOutput("hold_idle_nf", n_f, 1);
        checkOutput("hold_idle_cf", c_f, 1);

        // Same-floor request while idle at ground
        reset = 1'b1;
        applyStimulus(3'b000, 1);
        reset = 1'b0;
        applyStimulus(3'b001, 1);
        checkOutput("same_door", door_open, 1);
        checkOutput("same_moving", moving, 0);
        checkOutput("same_pending", pending, 0);
        checkOutput("same_nf", n_f, 0);
        applyStimulus(3'b000, 3);
        checkOutput("same_door_closed", door_open, 0);
        checkOutput("same_moving_end", moving, 0);
        checkOutput("same_pending_end", pending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_motion_scheduler.md
Name: elevator_motion_scheduler

Overview:
Request scheduler and motion sequencer for the 3-floor elevator controller. It latches floor requests from the ground, first and second floor buttons into a pending set and picks the next target floor with SCAN ordering: keep the current direction while requests lie ahead, then reverse. It times floor-to-floor travel and door dwell. Current floor, target floor and pending-request LEDs feed the existing floor-display/LED logic.

Parameters:
TRAVEL_TICKS, 4, clock cycles spent in a move state per one-floor step (>=1)
DOOR_TICKS, 3, clock cycles door stays open per stop (>=1)
TMR_W, 8, timer width; must hold max(TRAVEL_TICKS, DOOR_TICKS)-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  3  level request buttons; bit0 ground (B0), bit1 first (B1), bit2 second (B2)
c_f  output  2  current floor (00 ground, 01 first, 10 second); 11 never driven
n_f  output  2  target floor currently being served; equals c_f when idle with no requests
pending  output  3  latched outstanding requests, drives per-floor LEDs
door_open  output  1  high while in DOOR_OPEN
moving  output  1  high while in MOVE_UP or MOVE_DOWN
dir_up  output  1  SCAN direction preference; 1 up, 0 down

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset (synchronous, also mid-operation): on the next edge state=IDLE, c_f=0, n_f=0, pending=000, door_open=0, moving=0, dir_up=1, timers=0. A req bit asserted in the reset cycle is discarded.
- Pending update: eff = pending | req each cycle. The bit for c_f is cleared on any edge that enters or stays in DOOR_OPEN. All other bits keep eff.
- above = any eff bit > c_f; below = any eff bit < c_f.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Outputs are registered. moving and door_open decode the state.
- IDLE, checked in priority order:
  - eff[c_f] -> DOOR_OPEN, door timer = DOOR_TICKS-1.
  - dir_up and above -> MOVE_UP.
  - !dir_up and below -> MOVE_DOWN.
  - above -> MOVE_UP, dir_up=1.
  - below -> MOVE_DOWN, dir_up=0.
  - otherwise stay in IDLE.
  - On entering a move state, travel timer = TRAVEL_TICKS-1.
  - Latency: a request at another floor sampled in IDLE at cycle N makes moving=1 after edge N+1.
- MOVE_UP/MOVE_DOWN:
  - The timer decrements each cycle. When it is 0, c_f steps +1/-1 on that edge, so each floor step takes exactly TRAVEL_TICKS cycles.
  - On arrival, evaluated against the new floor: eff[new floor] -> DOOR_OPEN (clear that bit).
  - Else if requests remain further in the same direction -> stay in the move state and reload the timer.
  - Else -> IDLE.
  - c_f is never stepped below 0 or above 2. A move state is only entered when a request exists in that direction.
- DOOR_OPEN:
  - The door timer decrements each cycle; at 0 -> IDLE.
  - req[c_f] during DOOR_OPEN reloads the timer to DOOR_TICKS-1 (door hold). The pending bit stays clear.
- n_f (registered):
  - In a move state: nearest eff floor in the travel direction.
  - In DOOR_OPEN: c_f.
  - In IDLE: the floor chosen by the IDLE rules, or c_f if there is none.
- Simultaneous requests: all bits latch; service order follows SCAN only, with no fixed button priority.

Decomposition:
- Shared package elevator_pkg holds:
  - floor encodings FLOOR_G=2'b00, FLOOR_1=2'b01, FLOOR_2=2'b10, NUM_FLOORS=3;
  - state typedef/encoding IDLE=2'b00, MOVE_UP=2'b01, MOVE_DOWN=2'b10, DOOR_OPEN=2'b11.
- One sub-module, elev_tick_timer: a down-counter with load, load value, decrement enable and zero flag. It is instantiated twice, once for travel and once for the door.

Test Plan:
- Assert reset 2 cycles mid-motion -> next edge: c_f=00, n_f=00, pending=000, door_open=0, moving=0, dir_up=1.
- At floor 0 idle, pulse req=100 for 1 cycle -> pending=100, n_f=10, moving=1; c_f=01 after 4 cycles, c_f=10 after 8; then door_open=1 for 3 cycles, pending=000, return to IDLE.
- Intermediate stop: from floor 0, req=100, then req=010 during the first step -> stop at c_f=01, door 3 cycles, pending=100; continue to 10.
- SCAN order: at c_f=01 moving up toward 10, add req=001 -> serve 10 first (door), then dir_up=0, travel to 00, door open, pending=000.
- Door hold: at c_f=01 in DOOR_OPEN, hold req=010 for 5 cycles -> door_open stays high until 3 cycles after release; pending[1] stays 0.
- Same-floor request in IDLE at c_f=00: req=001 -> DOOR_OPEN on the next edge, moving never asserted, pending stays 000.
